// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback from the opcode and bounds every memory wait with a timeout.
module multicycle_control #(
  parameter int WAIT_LIMIT = 255,
  parameter int WCNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUop,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t            cur, nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_next;
  logic              wait_state;
  logic              at_limit;

  assign at_limit = (wcnt == WCNT_W'(WAIT_LIMIT));
  assign state    = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur  <= FETCH;
      wcnt <= '0;
    end else begin
      cur  <= nxt;
      wcnt <= wcnt_next;
    end
  end

  always_comb begin
    nxt         = cur;
    wait_state  = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUop       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;

    case (cur)
      FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        wait_state = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          nxt     = DECODE;
        end else if (at_limit) begin
          mem_timeout = 1'b1;
          nxt         = FETCH;
        end
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_RTYPE:      nxt = EXEC;
          OP_LW, OP_SW:  nxt = MEMADR;
          OP_BEQ:        nxt = BRANCH;
          OP_J:          nxt = JUMP;
          OP_ADDI:       nxt = ADDIEX;
          default: begin
            illegal_op = 1'b1;
            nxt        = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = (Op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        wait_state = 1'b1;
        if (mem_ready) begin
          nxt = MEMWB;
        end else if (at_limit) begin
          mem_timeout = 1'b1;
          nxt         = FETCH;
        end
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        nxt      = FETCH;
      end
      MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        wait_state = 1'b1;
        if (mem_ready) begin
          nxt = FETCH;
        end else if (at_limit) begin
          mem_timeout = 1'b1;
          nxt         = FETCH;
        end
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
        nxt     = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        nxt      = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        nxt         = FETCH;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        nxt      = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        nxt      = FETCH;
      end
      default: nxt = FETCH;
    endcase

    // Counter runs only while stalled in the same memory state; any exit clears it.
    wcnt_next = (wait_state && !mem_ready && !mem_timeout) ? wcnt + WCNT_W'(1) : '0;

    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      PCSource    = 2'b00;
      ALUop       = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      illegal_op  = 1'b0;
      mem_timeout = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps from the 6-bit opcode.
- Drives the 2-bit ALUop consumed by the ALU control decoder, plus all datapath mux selects and write enables.
- Handles variable-latency memory through a ready handshake with a bounded wait.

Parameters:
- WAIT_LIMIT, 255: maximum consecutive cycles in a memory state with mem_ready low before abort (1..255).
- WCNT_W, 8: width of the wait counter.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
Op  in  6  opcode field from the instruction register
mem_ready  in  1  memory completes the current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load qualified by ALU zero (beq)
IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
MemtoReg  out  1  1 = register write data comes from MDR
IRWrite  out  1  instruction register load
PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
ALUop  out  2  00 = add, 01 = subtract, 10 = use funct field
ALUSrcA  out  1  0 = PC, 1 = register A
ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
RegWrite  out  1  register file write
RegDst  out  1  1 = rd destination, 0 = rt destination
state  out  4  current state encoding (debug)
illegal_op  out  1  one-cycle pulse: unsupported opcode in DECODE
mem_timeout  out  1  one-cycle pulse: memory wait aborted

Behaviour:
- Reset:
  - State goes to FETCH (0) and the wait counter to 0.
  - While reset is high, all enables (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) and both pulses are forced to 0. All selects read 0.
- Outputs are Moore-decoded from state, except the FETCH IRWrite/PCWrite qualification by mem_ready. Unlisted outputs are 0.
- States, outputs and transitions:
  - FETCH (0): MemRead=1, ALUSrcB=01.
    - When mem_ready=1: IRWrite=1, PCWrite=1, go to DECODE. Otherwise hold.
  - DECODE (1): ALUSrcB=11. Next state by opcode:
    - R-type 000000 -> EXEC (6)
    - lw 100011 or sw 101011 -> MEMADR (2)
    - beq 000100 -> BRANCH (8)
    - j 000010 -> JUMP (9)
    - addi 001000 -> ADDIEX (10)
    - any other opcode -> FETCH, illegal_op=1 for this cycle.
  - MEMADR (2): ALUSrcA=1, ALUSrcB=10. lw -> MEMRD (3); sw -> MEMWR (5).
  - MEMRD (3): MemRead=1, IorD=1. When mem_ready=1 -> MEMWB (4). Otherwise hold.
  - MEMWB (4): RegWrite=1, MemtoReg=1, RegDst=0. Next: FETCH.
  - MEMWR (5): MemWrite=1, IorD=1. When mem_ready=1 -> FETCH. Otherwise hold.
  - EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUop=10. Next: ALUWB (7).
  - ALUWB (7): RegWrite=1, RegDst=1. Next: FETCH.
  - BRANCH (8): ALUSrcA=1, ALUop=01, PCWriteCond=1, PCSource=01. Next: FETCH.
  - JUMP (9): PCWrite=1, PCSource=10. Next: FETCH.
  - ADDIEX (10): ALUSrcA=1, ALUSrcB=10, ALUop=00. Next: ADDIWB (11).
  - ADDIWB (11): RegWrite=1, RegDst=0, MemtoReg=0. Next: FETCH.
  - Encodings 12-15 are unreachable and return to FETCH with all outputs 0.
- Cycle counts with zero memory wait:
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
  - Each low cycle of mem_ready adds one cycle.
- Wait counter:
  - Increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
  - Clears on any state change or when mem_ready=1.
- Timeout:
  - If the counter equals WAIT_LIMIT while mem_ready=0, the FSM goes to FETCH and asserts mem_timeout for one cycle.
  - In that cycle it asserts no IRWrite, PCWrite or RegWrite; the PC is left unchanged.
  - A timeout raised in FETCH re-enters FETCH with the counter cleared.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Op is sampled only in DECODE and MEMADR. Op is stable because IR loads only in FETCH.
- Reset asserted mid-instruction aborts immediately and asynchronously to FETCH. No write enable glitches high.

Test Plan:
- Reset, then R-type (Op=000000), mem_ready tied 1 -> state sequence 0,1,6,7,0. ALUop=10 in EXEC; RegWrite=1 with RegDst=1 in ALUWB.
- lw (Op=100011), mem_ready low 3 cycles in MEMRD -> MEMRD held 3 cycles with MemRead=1 and IorD=1. Sequence is 0,1,2,3,3,3,3,4,0; MemtoReg=1 and RegWrite=1 in MEMWB.
- sw, then beq, then j, with mem_ready tied 1:
  - sw: 0,1,2,5,0 with MemWrite=1 for one cycle.
  - beq: ALUop=01, PCWriteCond=1, PCSource=01.
  - j: PCWrite=1, PCSource=10.
- Op=111111 in DECODE -> illegal_op pulses 1 cycle, next state 0, RegWrite never asserted.
- WAIT_LIMIT=4, mem_ready held 0 in FETCH -> mem_timeout pulses after 5 FETCH cycles. IRWrite and PCWrite stay 0; FETCH restarts.
- Reset asserted while in MEMWR with MemWrite=1 -> MemWrite drops to 0 in the same cycle, state=0. After release, fetch resumes normally.
